div_core_arbiter: RTL and testbench
===================================

# div_core_arbiter

Shares one unsigned iterative divider core between NUM_REQ requesters, e.g. the integer div unit of two harts, or the integer and an auxiliary divide path. The block arbitrates round-robin, sequences start/done on the core, and holds each result on a shared response bus until the owning requester acknowledges it. It sits between the requesters' operand-preparation logic (sign handling, CLZ) and the divider core. All data is unsigned.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- DIV_WIDTH, 32, operand width; CLZ fields are $clog2(DIV_WIDTH) bits

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  one-hot accept; handshake completes when valid and ready are both high
- req_dividend  in  NUM_REQ×DIV_WIDTH  unsigned dividends
- req_divisor  in  NUM_REQ×DIV_WIDTH  unsigned divisors
- req_dividend_clz, req_divisor_clz  in  NUM_REQ×CLZW  leading-zero counts
- req_divisor_is_zero  in  NUM_REQ  divide-by-zero flag
- core_start  out  1  single-cycle start pulse to the divider
- core_dividend, core_divisor  out  DIV_WIDTH  operands to the core
- core_dividend_clz, core_divisor_clz  out  CLZW  CLZ values to the core
- core_divisor_is_zero  out  1  divide-by-zero flag to the core
- core_done  in  1  single-cycle pulse; quotient and remainder are valid in that cycle
- core_quotient, core_remainder  in  DIV_WIDTH  core results
- resp_valid  out  NUM_REQ  one-hot result-valid
- resp_ready  in  NUM_REQ  per-requester acknowledge
- resp_quotient, resp_remainder  out  DIV_WIDTH  registered results, shared by all requesters

## Operation
- FSM states:
  - IDLE
    - With any req_valid set, grant winner g, assert req_ready[g] and core_start in the same cycle, drive core_* combinationally from g's inputs, latch g, go BUSY.
    - With no req_valid, stay in IDLE.
  - BUSY
    - On core_done, register quotient and remainder and go HOLD.
    - Ignore all req_valid.
  - HOLD
    - resp_valid[g]=1.
    - On resp_ready[g], go IDLE.
    - resp_ready on any other bit is ignored.
- Round-robin:
  - The priority pointer is 0 after reset.
  - After a grant to g, the pointer becomes (g+1) mod NUM_REQ.
  - The winner is the first valid index at or after the pointer, wrapping.
  - The pointer updates only on accept.
- req_ready is zero outside IDLE. A requester may hold req_valid indefinitely, and its operands must stay stable until accepted.
- core_start never asserts outside IDLE, so there is at most one operation in the core.
- A core_done outside BUSY is ignored.
- A divisor_is_zero request is passed through unchanged. The core defines the result; the arbiter does not special-case it.

## Timing
- Reset values:
  - state IDLE, pointer 0, all req_ready 0 (combinational, IDLE with no valid)
  - core_start 0
  - resp_valid 0
  - resp_quotient/resp_remainder 0
  - cache invalid
- Cycle timing:
  - Accept at cycle T, core_start at T.
  - core_done at T+L, where L is the core latency.
  - resp_valid at T+L+1.
  - Ack at cycle A, IDLE at A+1; the next accept is at A+1 at the earliest.
- Throughput: one operation per L+2 cycles with immediate ack.
- Reset asserted mid-BUSY/HOLD aborts the operation; the result is lost and the requester must reissue. The core shares rst.
- A simultaneous core_done and rst: rst wins.

## Configuration
- DIV_ARB_RESULT_CACHE_EN defined:
  - One-entry cache holding {dividend, divisor, divisor_is_zero, quotient, remainder, valid}, written on every core_done.
  - In IDLE, a winner whose operands match a valid entry is accepted without core_start. The FSM goes straight to HOLD with the cached results, so resp_valid appears at T+1.
  - The pointer updates as for a normal grant.
- Undefined: there is no cache and every grant starts the core.

## Structure
- Shared package cva5_types holds div_arb_state_t (IDLE/BUSY/HOLD enum) and div_arb_cache_t (cache entry struct).
- One sub-module, div_rr_arbiter, is parameterised by NUM_REQ:
  - inputs: request vector, pointer-advance enable
  - outputs: one-hot grant, grant index
  - holds the priority pointer internally

## Test plan
- Single request: req 0, 100/7, core L=33 → core_start at T, resp_valid[0] at T+34, quotient 14, remainder 2; with ack held high, state is IDLE at T+35.
- Contention: req 0 and req 1 both valid continuously → grants alternate 0,1,0,1; neither is granted twice in a row.
- Delayed ack: resp_ready[1] held low 10 cycles after resp_valid[1] → result held stable; req 0 stays unaccepted; resp_ready[0]=1 has no effect.
- Divide by zero: req 1, 5/0, is_zero=1 → core result forwarded unchanged (quotient all-ones, remainder 5 from the core).
- Reset mid-BUSY: rst at T+5 → resp_valid stays 0, pointer 0; the same request reissued completes normally.
- With DIV_ARB_RESULT_CACHE_EN: 100/7 twice back-to-back → second has no core_start and resp_valid at T+1 with 14/2; 100/8 then misses and starts the core.

Source files
------------

// File: rtl/div_core_arbiter_pkg.sv
// div_core_arbiter_pkg: shared types for the divider-core arbiter
// Package cva5_types: FSM state enum, one-entry result-cache record, CLZ width helper.
// Cache fields are sized for the widest supported operand and zero-extended.
package cva5_types;
    localparam int DIV_ARB_MAX_WIDTH = 64;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} div_arb_state_t;
    typedef struct packed {
        logic [DIV_ARB_MAX_WIDTH-1:0] dividend;
        logic [DIV_ARB_MAX_WIDTH-1:0] divisor;
        logic                         divisor_is_zero;
        logic [DIV_ARB_MAX_WIDTH-1:0] quotient;
        logic [DIV_ARB_MAX_WIDTH-1:0] remainder;
        logic                         valid;
    } div_arb_cache_t;
    function automatic int div_arb_clzw(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/div_core_arbiter_if.sv
// div_core_arbiter_if: requester/response bus between requesters and the divider arbiter
// req_valid/req_ready          per-requester request handshake (ready is one-hot)
// req_dividend/req_divisor     per-requester unsigned operands
// req_*_clz, req_divisor_is_zero  per-requester operand preparation results
// resp_valid/resp_ready        one-hot result valid, per-requester acknowledge
// resp_quotient/resp_remainder shared registered results
// master: requester side, slave: arbiter side
interface div_core_arbiter_if
    import cva5_types::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DIV_WIDTH = 32
);
    localparam int CLZW = div_arb_clzw(DIV_WIDTH);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][DIV_WIDTH-1:0] req_dividend;
    logic [NUM_REQ-1:0][DIV_WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0][CLZW-1:0]      req_dividend_clz;
    logic [NUM_REQ-1:0][CLZW-1:0]      req_divisor_clz;
    logic [NUM_REQ-1:0]                req_divisor_is_zero;
    logic [NUM_REQ-1:0]                resp_valid;
    logic [NUM_REQ-1:0]                resp_ready;
    logic [DIV_WIDTH-1:0]              resp_quotient;
    logic [DIV_WIDTH-1:0]              resp_remainder;
    modport master (
        output req_valid, req_dividend, req_divisor, req_dividend_clz, req_divisor_clz,
               req_divisor_is_zero, resp_ready,
        input  req_ready, resp_valid, resp_quotient, resp_remainder
    );
    modport slave (
        input  req_valid, req_dividend, req_divisor, req_dividend_clz, req_divisor_clz,
               req_divisor_is_zero, resp_ready,
        output req_ready, resp_valid, resp_quotient, resp_remainder
    );
endinterface

// File: rtl/div_core_arbiter_rr.sv
// div_rr_arbiter: round-robin grant with an internal priority pointer
// clk, rst      clock, synchronous active-high reset (pointer returns to 0)
// req           request vector
// adv           advance pointer to grant_idx+1 (asserted on accept)
// grant         one-hot winner, zero when no request
// grant_idx     winner index
module div_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);
    localparam int SW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ - 1){1'b0}}, 1'b1};
    logic [IW-1:0] ptr;
    logic [SW-1:0] s;
    // Scan from the farthest candidate back to the pointer so the first valid
    // index at or after the pointer is the last one written.
    always_comb begin
        grant_idx = '0;
        s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + SW'(i);
            s = s >= SW'(NUM_REQ) ? s - SW'(NUM_REQ) : s;
            grant_idx = req[s[IW-1:0]] ? s[IW-1:0] : grant_idx;
        end
        grant = |req ? ONE << grant_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= grant_idx == LAST ? '0 : grant_idx + 1'b1;
    end
endmodule

// File: rtl/div_core_arbiter.sv
// div_core_arbiter: round-robin sharing of one iterative divider core between NUM_REQ requesters
// clk, rst                       clock, synchronous active-high reset (shared with the core)
// bus (slave)                    requester handshake, operands, one-hot response bus
// core_start                     single-cycle start, asserted in the accept cycle
// core_dividend/divisor/_clz     winner's operands, driven combinationally
// core_divisor_is_zero           winner's divide-by-zero flag, passed through
// core_done, core_quotient/remainder  core completion pulse and results
// Optional feature: define DIV_ARB_RESULT_CACHE_EN for a one-entry result cache
// that answers a repeated operation without starting the core.
module div_core_arbiter
    import cva5_types::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DIV_WIDTH = 32,
    localparam int CLZW = div_arb_clzw(DIV_WIDTH),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    div_core_arbiter_if.slave    bus,
    output logic                 core_start,
    output logic [DIV_WIDTH-1:0] core_dividend,
    output logic [DIV_WIDTH-1:0] core_divisor,
    output logic [CLZW-1:0]      core_dividend_clz,
    output logic [CLZW-1:0]      core_divisor_clz,
    output logic                 core_divisor_is_zero,
    input  logic                 core_done,
    input  logic [DIV_WIDTH-1:0] core_quotient,
    input  logic [DIV_WIDTH-1:0] core_remainder
);
    div_arb_state_t       state;
    logic [NUM_REQ-1:0]   win;
    logic [NUM_REQ-1:0]   own;
    logic [IW-1:0]        win_idx;
    logic                 accept;
    logic                 hit;
    logic [DIV_WIDTH-1:0] hit_q;
    logic [DIV_WIDTH-1:0] hit_r;
    div_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk(clk),
        .rst(rst),
        .req(bus.req_valid),
        .adv(accept),
        .grant(win),
        .grant_idx(win_idx)
    );
    assign accept = state == IDLE && |bus.req_valid;
    assign bus.req_ready = accept ? win : '0;
    assign core_start = accept && !hit;
    assign core_dividend = bus.req_dividend[win_idx];
    assign core_divisor = bus.req_divisor[win_idx];
    assign core_dividend_clz = bus.req_dividend_clz[win_idx];
    assign core_divisor_clz = bus.req_divisor_clz[win_idx];
    assign core_divisor_is_zero = bus.req_divisor_is_zero[win_idx];
`ifdef DIV_ARB_RESULT_CACHE_EN
    div_arb_cache_t cache;
    assign hit = cache.valid
        && cache.dividend == DIV_ARB_MAX_WIDTH'(core_dividend)
        && cache.divisor == DIV_ARB_MAX_WIDTH'(core_divisor)
        && cache.divisor_is_zero == core_divisor_is_zero;
    assign hit_q = cache.quotient[DIV_WIDTH-1:0];
    assign hit_r = cache.remainder[DIV_WIDTH-1:0];
    // Operands are captured at start with the entry invalidated, so an
    // operation aborted by reset can never leave a stale pairing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache <= '0;
        end else if (core_start) begin
            cache.dividend <= DIV_ARB_MAX_WIDTH'(core_dividend);
            cache.divisor <= DIV_ARB_MAX_WIDTH'(core_divisor);
            cache.divisor_is_zero <= core_divisor_is_zero;
            cache.valid <= 1'b0;
        end else if (state == BUSY && core_done) begin
            cache.quotient <= DIV_ARB_MAX_WIDTH'(core_quotient);
            cache.remainder <= DIV_ARB_MAX_WIDTH'(core_remainder);
            cache.valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_q = '0;
    assign hit_r = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own <= '0;
            bus.resp_valid <= '0;
            bus.resp_quotient <= '0;
            bus.resp_remainder <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    own <= win;
                    state <= hit ? HOLD : BUSY;
                    if (hit) begin
                        bus.resp_valid <= win;
                        bus.resp_quotient <= hit_q;
                        bus.resp_remainder <= hit_r;
                    end
                end
                BUSY: if (core_done) begin
                    state <= HOLD;
                    bus.resp_valid <= own;
                    bus.resp_quotient <= core_quotient;
                    bus.resp_remainder <= core_remainder;
                end
                HOLD: if (|(bus.resp_ready & own)) begin
                    state <= IDLE;
                    bus.resp_valid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_core_arbiter.sv
// tb_div_core_arbiter: directed and randomized checks of div_core_arbiter against a reference model
module tb_div_core_arbiter;
    localparam int N = 2;
    localparam int W = 32;
    localparam int CW = $clog2(W);
    localparam int L = 33;
    localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};
`ifdef DIV_ARB_RESULT_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_start, core_divisor_is_zero, core_done;
    logic done_m = 1'b0;
    logic spur = 1'b0;
    logic [W-1:0] core_dividend, core_divisor;
    logic [W-1:0] core_quotient = '0;
    logic [W-1:0] core_remainder = '0;
    logic [CW-1:0] core_dividend_clz, core_divisor_clz;
    logic [W-1:0] ma, mb;
    logic mz;
    int cnt_m = 0;
    int n_cmp = 0;
    int n_err = 0;
    int ptr = 0;
    int g;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    logic z [N];
    logic [CW-1:0] da [N];
    logic [CW-1:0] db [N];
    bit cvalid = 1'b0;
    logic [W-1:0] cav, cbv;
    logic czv;

    div_core_arbiter_if #(.NUM_REQ(N), .DIV_WIDTH(W)) bus ();

    div_core_arbiter #(.NUM_REQ(N), .DIV_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .core_start(core_start),
        .core_dividend(core_dividend),
        .core_divisor(core_divisor),
        .core_dividend_clz(core_dividend_clz),
        .core_divisor_clz(core_divisor_clz),
        .core_divisor_is_zero(core_divisor_is_zero),
        .core_done(core_done),
        .core_quotient(core_quotient),
        .core_remainder(core_remainder)
    );

    always #5 clk = ~clk;

    assign core_done = done_m | spur;

    // Divider core stand-in: fixed latency L, all-ones quotient on divide-by-zero.
    always @(posedge clk) begin
        done_m <= 1'b0;
        if (rst) begin
            cnt_m <= 0;
        end else if (core_start) begin
            cnt_m <= L - 1;
            ma <= core_dividend;
            mb <= core_divisor;
            mz <= core_divisor_is_zero;
        end else if (cnt_m != 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) begin
                done_m <= 1'b1;
                core_quotient <= mz ? '1 : ma / mb;
                core_remainder <= mz ? ma : ma % mb;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int i = 0; i < N; i++)
            if (m[(ptr + i) % N]) return (ptr + i) % N;
        return 0;
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        a[i] = x;
        b[i] = y;
        z[i] = y == '0;
        da[i] = CW'($urandom);
        db[i] = CW'($urandom);
        bus.req_dividend[i] = x;
        bus.req_divisor[i] = y;
        bus.req_divisor_is_zero[i] = z[i];
        bus.req_dividend_clz[i] = da[i];
        bus.req_divisor_clz[i] = db[i];
    endtask

    task automatic rnd_op(input int i);
        set_op(i, W'($urandom), $urandom_range(0, 7) == 0 ? '0 : W'($urandom));
    endtask

    // One transaction from the accept cycle through the acknowledge.
    task automatic txn(input int ack_dly, input bit other_ack, input bit keep, output int gw);
        int cnt;
        bit hit;
        logic [W-1:0] eq, er;
        logic [N-1:0] gm;
        #1;
        gw = pick(bus.req_valid);
        gm = ONE << gw;
        hit = CACHE && cvalid && cav == a[gw] && cbv == b[gw] && czv == z[gw];
        eq = z[gw] ? '1 : a[gw] / b[gw];
        er = z[gw] ? a[gw] : a[gw] % b[gw];
        chk("req_ready", 64'(bus.req_ready), 64'(gm));
        chk("core_start", 64'(core_start), 64'(!hit));
        chk("core_dividend", 64'(core_dividend), 64'(a[gw]));
        chk("core_divisor", 64'(core_divisor), 64'(b[gw]));
        chk("core_dividend_clz", 64'(core_dividend_clz), 64'(da[gw]));
        chk("core_divisor_clz", 64'(core_divisor_clz), 64'(db[gw]));
        chk("core_is_zero", 64'(core_divisor_is_zero), 64'(z[gw]));
        ptr = (gw + 1) % N;
        @(negedge clk);
        if (!keep) bus.req_valid[gw] = 1'b0;
        #1;
        cnt = 1;
        while (bus.resp_valid == '0 && cnt < 200) begin
            chk("busy_req_ready", 64'(bus.req_ready), 64'(0));
            chk("busy_core_start", 64'(core_start), 64'(0));
            @(negedge clk);
            #1;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'(hit ? 1 : L + 1));
        chk("resp_valid", 64'(bus.resp_valid), 64'(gm));
        chk("resp_quotient", 64'(bus.resp_quotient), 64'(eq));
        chk("resp_remainder", 64'(bus.resp_remainder), 64'(er));
        if (!hit) begin
            cvalid = 1'b1;
            cav = a[gw];
            cbv = b[gw];
            czv = z[gw];
        end
        bus.resp_ready = other_ack ? ~gm : '0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 64'(bus.resp_valid), 64'(gm));
            chk("hold_quotient", 64'(bus.resp_quotient), 64'(eq));
            chk("hold_remainder", 64'(bus.resp_remainder), 64'(er));
            chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.resp_ready = gm;
        @(negedge clk);
        #1;
        chk("ack_release", 64'(bus.resp_valid), 64'(0));
        bus.resp_ready = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.resp_ready = '0;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.req_dividend_clz = '0;
        bus.req_divisor_clz = '0;
        bus.req_divisor_is_zero = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_core_start", 64'(core_start), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_quotient", 64'(bus.resp_quotient), 64'(0));
        chk("rst_remainder", 64'(bus.resp_remainder), 64'(0));
        rst = 1'b0;

        set_op(0, 100, 7);
        bus.req_valid = 2'b01;
        txn(0, 1'b0, 1'b0, g);

        rnd_op(0);
        rnd_op(1);
        bus.req_valid = 2'b11;
        txn(10, 1'b1, 1'b0, g);
        txn(0, 1'b0, 1'b0, g);

        set_op(1, 5, 0);
        bus.req_valid = 2'b10;
        txn(0, 1'b0, 1'b0, g);

        rnd_op(0);
        rnd_op(1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            txn(0, 1'b0, 1'b1, g);
            rnd_op(g);
        end
        bus.req_valid = '0;

        @(negedge clk);
        set_op(0, W'($urandom), W'($urandom_range(1, 1000)));
        bus.req_valid = 2'b01;
        #1;
        chk("abort_accept", 64'(bus.req_ready), 64'(ONE << pick(bus.req_valid)));
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        cvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            chk("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
        end
        rnd_op(1);
        bus.req_valid = 2'b11;
        txn(0, 1'b0, 1'b0, g);
        txn(0, 1'b0, 1'b0, g);

        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        #1;
        chk("spurious_done", 64'(bus.resp_valid), 64'(0));

        set_op(0, 100, 7);
        bus.req_valid = 2'b01;
        txn(0, 1'b0, 1'b0, g);
        set_op(0, 100, 7);
        bus.req_valid = 2'b01;
        txn(0, 1'b0, 1'b0, g);
        set_op(0, 100, 8);
        bus.req_valid = 2'b01;
        txn(0, 1'b0, 1'b0, g);

        for (int k = 0; k < 12; k++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (m[i] && !bus.req_valid[i]) rnd_op(i);
            bus.req_valid = bus.req_valid | m;
            txn(int'($urandom_range(0, 3)), 1'($urandom), 1'b0, g);
        end
        while (bus.req_valid != '0) txn(0, 1'b0, 1'b0, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
